onehot_pin_decoder: RTL and testbench
=====================================

// Module: onehot_pin_decoder
//
// PURPOSE
//   Input-side counterpart of the one-hot PMOD output driver. Samples a WIDTH-bit
//   PMOD input bus and synchronises and debounces it. Classifies the stable value
//   as none, one-hot or multi-hot, and reports the active pin as a binary index
//   with a single-cycle VALID strobe. Sits between the PMOD input pins and the
//   user logic.
//
// PARAMETERS
//   WIDTH          24  number of input pins (bit 0 = PINS_IN[0])
//   IDX_BITS        5  width of IDX; must satisfy 2^IDX_BITS >= WIDTH
//   DEBOUNCE_LOG2  16  the bus must be stable for 2^DEBOUNCE_LOG2 cycles to be accepted
//
// PORTS
//   CLK        in   1         system clock; the only clock
//   RST        in   1         synchronous reset, active-high
//   PINS_IN    in   WIDTH     raw asynchronous pin levels, active-high
//   IDX        out  IDX_BITS  index of the accepted pin; holds its value between events
//   VALID      out  1         one-cycle pulse when a new pin press is accepted
//   HELD       out  1         high while the accepted pin remains pressed
//   ERR        out  1         high while the stable value is an illegal multi-hot value
//   EVENT_CNT  out  8         count of VALID pulses; wraps from 255 to 0
//
// BEHAVIOUR
//   - Reset:
//     - RST is sampled on CLK. It clears the sync flops, the candidate, the
//       debounce counter and the stable register, and puts the FSM in IDLE.
//     - All outputs are 0 on the cycle after RST is sampled high.
//     - An assertion mid-debounce or mid-press discards all history.
//   - Synchroniser: two flops, s1 then s2.
//   - Debounce:
//     - If s2 != cand: cand <= s2 and cnt <= 0.
//     - Otherwise cnt increments and saturates at 2^DEBOUNCE_LOG2-1.
//     - On the edge where cnt reaches that maximum, stable <= cand.
//     - Total delay: stable updates exactly 2^DEBOUNCE_LOG2+2 cycles after the
//       first CLK edge that samples the new PINS_IN value.
//     - Any glitch during the window restarts the count.
//   - Classification of stable: ZERO (all 0), ONE (exactly one bit set), MULTI (two or more).
//   - FSM (states IDLE, ACTIVE, FAULT), evaluated on the cycle after stable updates:
//     - IDLE -> ACTIVE on ONE:
//       - IDX <= position of the set bit.
//       - VALID = 1 for one cycle.
//       - EVENT_CNT increments.
//     - IDLE -> FAULT on MULTI.
//     - ACTIVE -> IDLE on ZERO. IDX holds its value.
//     - ACTIVE -> FAULT on any other non-zero value. No VALID is issued.
//     - FAULT -> IDLE on ZERO only.
//     - HELD = (state == ACTIVE). ERR = (state == FAULT).
//   - Only a return to all-zero re-arms the FSM. A pin held continuously produces
//     exactly one VALID.
//   - A pin held while RST deasserts is seen as a fresh change: it is debounced,
//     then VALID is issued.
//   - EVENT_CNT wraps from 255 to 0. No other counters wrap: cnt saturates.
//   - Bits of PINS_IN above WIDTH-1 do not exist. IDX never exceeds WIDTH-1.
//
// CONFIGURATION
//   PRIORITY_EN (define to enable):
//   - Defined:
//     - MULTI is treated as ONE with the lowest set bit, so IDLE -> ACTIVE with
//       IDX = lowest index.
//     - In ACTIVE, a change to a different non-zero value stays in ACTIVE with no
//       new VALID, and IDX is unchanged.
//     - FAULT is unreachable and ERR is tied to 0.
//   - Undefined: MULTI behaviour is as described in BEHAVIOUR.
//
// TESTING (bench uses DEBOUNCE_LOG2=2: 6-cycle acceptance)
//   1. After reset, set PINS_IN=1<<5 and hold 20 cycles -> single VALID 7 cycles
//      after the change, IDX=5, HELD=1, EVENT_CNT=1.
//   2. Toggle PINS_IN[3] every 3 cycles for 30 cycles, then release -> no VALID,
//      EVENT_CNT unchanged.
//   3. Set PINS_IN=24'h000009 -> ERR=1, no VALID. Release -> ERR=0. With
//      PRIORITY_EN: VALID, IDX=0, ERR stays 0.
//   4. Press 23, then change to pin 7 without release -> FAULT, ERR=1, IDX stays
//      23. Release, then press 7 -> VALID, IDX=7.
//   5. Do 256 press/release cycles on pin 0 -> EVENT_CNT back to 0, 256 VALID
//      pulses counted.
//   6. Assert RST for 1 cycle while pin 12 is held in ACTIVE -> outputs 0; VALID
//      with IDX=12 is re-issued 7 cycles after RST deasserts.

Source files
------------

// File: rtl/onehot_pin_decoder.sv
// PMOD input decoder: synchronises and debounces a pin bus, then reports a single pressed pin
// as an index with a one-cycle VALID strobe. Define PRIORITY_EN to resolve multi-hot values to the lowest pin.
module onehot_pin_decoder #(
    parameter int unsigned WIDTH         = 24,
    parameter int unsigned IDX_BITS      = 5,
    parameter int unsigned DEBOUNCE_LOG2 = 16
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [WIDTH-1:0]    PINS_IN,
    output logic [IDX_BITS-1:0] IDX,
    output logic                VALID,
    output logic                HELD,
    output logic                ERR,
    output logic [7:0]          EVENT_CNT
);

    localparam logic [DEBOUNCE_LOG2-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        FAULT  = 2'd2
    } state_t;

    logic [WIDTH-1:0]         s1;
    logic [WIDTH-1:0]         s2;
    logic [WIDTH-1:0]         cand;
    logic [WIDTH-1:0]         stable;
    logic [DEBOUNCE_LOG2-1:0] cnt;

    state_t                   state;
    state_t                   state_next;

    logic                     is_zero;
    logic                     is_one;
    logic [IDX_BITS-1:0]      low_idx;

    logic                     accept_c;
    logic [IDX_BITS-1:0]      idx_next;
    logic [7:0]               event_cnt_next;

    // Two-flop synchroniser followed by a saturating stability counter
    always_ff @(posedge CLK) begin
        if (RST) begin
            s1     <= '0;
            s2     <= '0;
            cand   <= '0;
            cnt    <= '0;
            stable <= '0;
        end else begin
            s1 <= PINS_IN;
            s2 <= s1;
            if (s2 != cand) begin
                cand <= s2;
                cnt  <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + DEBOUNCE_LOG2'(1);
            end else begin
                stable <= cand;
            end
        end
    end

    // Classify the accepted value and locate its lowest set bit
    always_comb begin
        is_zero = (stable == '0);
        is_one  = !is_zero && ((stable & (stable - WIDTH'(1))) == '0);
        low_idx = '0;
        for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
            if (stable[i]) begin
                low_idx = IDX_BITS'(i);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (is_one) begin
                    state_next = ACTIVE;
                end else if (!is_zero) begin
`ifdef PRIORITY_EN
                    state_next = ACTIVE;
`else
                    state_next = FAULT;
`endif
                end
            end
            ACTIVE: begin
                if (is_zero) begin
                    state_next = IDLE;
                end
`ifndef PRIORITY_EN
                else if (!(is_one && (low_idx == IDX))) begin
                    state_next = FAULT;
                end
`endif
            end
            FAULT: begin
                if (is_zero) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A press is accepted only when leaving IDLE; ACTIVE never re-captures the index
    always_comb begin
        accept_c       = (state == IDLE) && (state_next == ACTIVE);
        idx_next       = IDX;
        event_cnt_next = EVENT_CNT;
        if (accept_c) begin
            idx_next       = low_idx;
            event_cnt_next = EVENT_CNT + 8'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            IDX       <= '0;
            VALID     <= 1'b0;
            HELD      <= 1'b0;
            ERR       <= 1'b0;
            EVENT_CNT <= '0;
        end else begin
            IDX       <= idx_next;
            VALID     <= accept_c;
            HELD      <= (state_next == ACTIVE);
`ifdef PRIORITY_EN
            ERR       <= 1'b0;
`else
            ERR       <= (state_next == FAULT);
`endif
            EVENT_CNT <= event_cnt_next;
        end
    end

endmodule

// File: tb/tb_onehot_pin_decoder.sv
// Bench for onehot_pin_decoder: directed scenarios plus random pin traffic against a
// sliding-window reference model. Honours PRIORITY_EN when defined.
module tb_onehot_pin_decoder;

    localparam int unsigned W  = 24;
    localparam int unsigned IB = 5;
    localparam int unsigned DL = 2;
`ifdef PRIORITY_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic          clk  = 1'b0;
    logic          rst  = 1'b1;
    logic [W-1:0]  pins = '0;
    logic [IB-1:0] idx;
    logic          valid;
    logic          held;
    logic          err;
    logic [7:0]    event_cnt;

    int            checks = 0;
    int            errors = 0;
    int            vcnt   = 0;
    bit            chk_en = 1'b0;
    logic [7:0]    exp_evt = '0;

    // reference model state
    logic [W-1:0]  h [0:6];
    logic [W-1:0]  m_stable = '0;
    logic [IB-1:0] m_idx    = '0;
    logic          m_valid  = 1'b0;
    logic          m_held   = 1'b0;
    logic          m_err    = 1'b0;
    logic [7:0]    m_evt    = '0;
    int            m_n;
    int            m_lo;

    always #5 clk = ~clk;

    onehot_pin_decoder #(
        .WIDTH        (W),
        .IDX_BITS     (IB),
        .DEBOUNCE_LOG2(DL)
    ) dut (
        .CLK      (clk),
        .RST      (rst),
        .PINS_IN  (pins),
        .IDX      (idx),
        .VALID    (valid),
        .HELD     (held),
        .ERR      (err),
        .EVENT_CNT(event_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int lowest(input logic [W-1:0] v);
        int r = 0;
        for (int i = int'(W) - 1; i >= 0; i--) begin
            if (v[i]) r = i;
        end
        return r;
    endfunction

    // Model: the pin value is accepted once five consecutive samples agree (window ending two
    // edges ago); the press logic reacts one edge after acceptance.
    always @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < 7; j++) h[j] = '0;
            m_stable = '0;
            m_idx    = '0;
            m_valid  = 1'b0;
            m_held   = 1'b0;
            m_err    = 1'b0;
            m_evt    = '0;
        end else begin
            m_n     = $countones(m_stable);
            m_lo    = lowest(m_stable);
            m_valid = 1'b0;
            if (m_held) begin
                if (m_n == 0) m_held = 1'b0;
                else if (!PRIO && !(m_n == 1 && m_lo == int'(m_idx))) begin
                    m_held = 1'b0;
                    m_err  = 1'b1;
                end
            end else if (m_err) begin
                if (m_n == 0) m_err = 1'b0;
            end else if (m_n == 1 || (PRIO && m_n > 1)) begin
                m_held  = 1'b1;
                m_idx   = IB'(m_lo);
                m_valid = 1'b1;
                m_evt   = m_evt + 8'd1;
            end else if (m_n > 1) begin
                m_err = 1'b1;
            end
            for (int j = 6; j > 0; j--) h[j] = h[j-1];
            h[0] = pins;
            if (h[2] == h[3] && h[3] == h[4] && h[4] == h[5] && h[5] == h[6]) m_stable = h[2];
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cycle", {idx, valid, held, err, event_cnt},
                  {m_idx, m_valid, m_held, m_err, m_evt});
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            if (valid === 1'b1) vcnt++;
        end
    endtask

    task automatic hold(input logic [W-1:0] v, input int n);
        pins = v;
        tick(n);
    endtask

    // Edges from the sampling edge to the first VALID; 99 if none within the budget.
    task automatic wait_valid(output int lat);
        lat = 99;
        for (int i = 1; i <= 20; i++) begin
            tick(1);
            if (valid === 1'b1 && lat == 99) lat = i - 1;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        int v0;
        logic [W-1:0] v;
        int a;
        int b;

        rst = 1'b1;
        tick(3);
        chk_en = 1'b1;
        check("rst_outs", {idx, valid, held, err, event_cnt}, 32'h0);
        rst = 1'b0;
        tick(2);

        // single press on pin 5
        v0   = vcnt;
        pins = W'(1) << 5;
        wait_valid(lat);
        exp_evt = exp_evt + 8'd1;
        check("t1_latency", lat, 7);
        check("t1_pulses", vcnt - v0, 1);
        check("t1_idx", idx, 5);
        check("t1_held", held, 1);
        check("t1_cnt", event_cnt, exp_evt);

        // bouncing pin never accepted
        hold('0, 12);
        check("t2_held_off", held, 0);
        v0 = vcnt;
        for (int i = 0; i < 10; i++) begin
            pins[3] = ~pins[3];
            tick(3);
        end
        hold('0, 12);
        check("t2_pulses", vcnt - v0, 0);
        check("t2_cnt", event_cnt, exp_evt);

        // multi-hot value
        v0 = vcnt;
        hold(24'h000009, 12);
        exp_evt = exp_evt + 8'(PRIO);
        check("t3_err", err, !PRIO);
        check("t3_held", held, PRIO);
        check("t3_pulses", vcnt - v0, PRIO);
        check("t3_idx", idx, PRIO ? 0 : 5);
        hold('0, 12);
        check("t3_err_clr", err, 0);
        check("t3_cnt", event_cnt, exp_evt);

        // slide from pin 23 to pin 7 without release
        v0 = vcnt;
        hold(W'(1) << 23, 12);
        check("t4_idx23", idx, 23);
        hold(W'(1) << 7, 12);
        check("t4_err", err, !PRIO);
        check("t4_held", held, PRIO);
        check("t4_idx_kept", idx, 23);
        check("t4_pulses_a", vcnt - v0, 1);
        hold('0, 12);
        hold(W'(1) << 7, 12);
        exp_evt = exp_evt + 8'd2;
        check("t4_idx7", idx, 7);
        check("t4_pulses_b", vcnt - v0, 2);
        check("t4_cnt", event_cnt, exp_evt);
        hold('0, 12);

        // 256 presses wrap the event counter
        v0 = vcnt;
        repeat (256) begin
            hold(W'(1), 8);
            hold('0, 8);
        end
        check("t5_pulses", vcnt - v0, 256);
        check("t5_cnt_wrap", event_cnt, exp_evt);

        // reset while pin 12 held
        hold(W'(1) << 12, 12);
        check("t6_held", held, 1);
        check("t6_idx_pre", idx, 12);
        rst = 1'b1;
        tick(1);
        check("t6_rst_outs", {idx, valid, held, err, event_cnt}, 32'h0);
        rst = 1'b0;
        v0 = vcnt;
        wait_valid(lat);
        exp_evt = 8'd1;
        check("t6_latency", lat, 7);
        check("t6_idx", idx, 12);
        check("t6_pulses", vcnt - v0, 1);
        check("t6_cnt", event_cnt, exp_evt);
        hold('0, 12);

        // random traffic against the model
        repeat (120) begin
            a = $urandom_range(0, W - 1);
            b = $urandom_range(0, W - 1);
            case ($urandom_range(0, 9))
                0, 1, 2:    v = '0;
                3, 4, 5, 6: v = W'(1) << a;
                default:    v = (W'(1) << a) | (W'(1) << b);
            endcase
            if ($urandom_range(0, 19) == 0) begin
                rst = 1'b1;
                tick(1);
                rst = 1'b0;
            end
            hold(v, $urandom_range(1, 12));
        end
        hold('0, 12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
